// File: rtl/wb_burst_master.sv
// Pipelined Wishbone burst master for one port of the dual-port RAM.
// Issues word-incrementing beats for a command, bounded by MAX_OUT outstanding acks.
module wb_burst_master #(
  parameter int LEN_W   = 8,
  parameter int MAX_OUT = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic             cmd_we,
  input  logic [10:0]      cmd_addr,
  input  logic [LEN_W-1:0] cmd_len,
  input  logic [3:0]       cmd_sel,
  input  logic             wdata_valid,
  output logic             wdata_ready,
  input  logic [31:0]      wdata,
  output logic             rdata_valid,
  output logic [31:0]      rdata,
  output logic             done,
  output logic             err,
  output logic             wb_cyc_o,
  output logic             wb_stb_o,
  output logic             wb_we_o,
  output logic [3:0]       wb_sel_o,
  output logic [10:0]      wb_addr_o,
  output logic [31:0]      wb_data_o,
  input  logic [31:0]      wb_data_i,
  input  logic             wb_ack_i,
  input  logic             wb_stall_i
);

  localparam int BW = LEN_W + 1;
  localparam logic [2:0] MAX_OUT_V = 3'(MAX_OUT);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;

  state_t         state, state_next;
  logic [BW-1:0]  beats_left, beats_next;
  logic [2:0]     outstanding, out_next;
  logic [10:0]    addr;
  logic           we, sel_we_next;
  logic [3:0]     sel;
  logic           stb, stb_next;
  logic           buf_full, full_next;
  logic [31:0]    buf_data;
  logic           cmd_fire, accept, ack_ok, wdata_fire, last_accept;

  assign cmd_fire    = cmd_valid && cmd_ready;
  assign accept      = stb && !wb_stall_i;
  assign ack_ok      = wb_ack_i && wb_cyc_o && (outstanding != 3'd0);
  assign wdata_fire  = wdata_valid && wdata_ready;
  assign last_accept = accept && (beats_left == BW'(1));

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (cmd_valid) state_next = ISSUE;
      ISSUE:   if (last_accept) state_next = DRAIN;
      DRAIN:   if (ack_ok && outstanding == 3'd1) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // The skid register may refill in the same cycle it hands a beat to the bus.
  always_comb begin
    cmd_ready   = (state == IDLE);
    wb_cyc_o    = (state != IDLE);
    wdata_ready = (state == ISSUE) && we &&
                  (!buf_full || (accept && beats_left > BW'(1)));
  end

  // stb is registered, so it is decided from the values the next cycle will see.
  always_comb begin
    out_next    = outstanding + 3'(accept) - 3'(ack_ok);
    beats_next  = cmd_fire ? ({1'b0, cmd_len} + BW'(1)) : (beats_left - BW'(accept));
    sel_we_next = cmd_fire ? cmd_we : we;
    full_next   = cmd_fire ? 1'b0 : (wdata_fire ? 1'b1 : (accept ? 1'b0 : buf_full));
    stb_next    = (state_next == ISSUE) && (beats_next != '0) &&
                  (out_next < MAX_OUT_V) && (!sel_we_next || full_next);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      beats_left  <= '0;
      outstanding <= 3'd0;
      addr        <= 11'd0;
      we          <= 1'b0;
      sel         <= 4'd0;
      stb         <= 1'b0;
      buf_full    <= 1'b0;
      buf_data    <= 32'd0;
      rdata_valid <= 1'b0;
      rdata       <= 32'd0;
      done        <= 1'b0;
      err         <= 1'b0;
    end else begin
      beats_left  <= beats_next;
      outstanding <= out_next;
      stb         <= stb_next;
      buf_full    <= full_next;
      if (cmd_fire) begin
        addr <= cmd_addr & 11'h7FC;
        we   <= cmd_we;
        sel  <= cmd_sel;
      end else if (accept) begin
        addr <= addr + 11'd4;
      end
      if (wdata_fire) buf_data <= wdata;
      rdata_valid <= ack_ok && !we;
      if (ack_ok && !we) rdata <= wb_data_i;
      done <= (state == DRAIN) && (state_next == IDLE);
      if (wb_ack_i && outstanding == 3'd0) err <= 1'b1;
    end
  end

  assign wb_stb_o  = stb;
  assign wb_we_o   = we;
  assign wb_sel_o  = sel;
  assign wb_addr_o = addr;
  assign wb_data_o = buf_data;

endmodule

// File: tb/tb_wb_burst_master.sv
// Directed bench for wb_burst_master: table of bursts against a Wishbone slave model,
// plus hand sequences for reset mid-burst and spurious acks.
module tb_wb_burst_master;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid, cmd_ready, cmd_we;
  logic [10:0] cmd_addr;
  logic [7:0]  cmd_len;
  logic [3:0]  cmd_sel;
  logic        wdata_valid, wdata_ready;
  logic [31:0] wdata;
  logic        rdata_valid;
  logic [31:0] rdata;
  logic        done, err;
  logic        cyc, stb, we_o;
  logic [3:0]  sel;
  logic [10:0] addr;
  logic [31:0] data_o, data_i;
  logic        ack, stall;

  always #5 clk = ~clk;

  wb_burst_master #(.LEN_W(8), .MAX_OUT(2)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len), .cmd_sel(cmd_sel),
    .wdata_valid(wdata_valid), .wdata_ready(wdata_ready), .wdata(wdata),
    .rdata_valid(rdata_valid), .rdata(rdata), .done(done), .err(err),
    .wb_cyc_o(cyc), .wb_stb_o(stb), .wb_we_o(we_o), .wb_sel_o(sel),
    .wb_addr_o(addr), .wb_data_o(data_o), .wb_data_i(data_i),
    .wb_ack_i(ack), .wb_stall_i(stall)
  );

  typedef struct {
    logic        we;
    logic [10:0] addr;
    logic [7:0]  len;
    logic [3:0]  sel;
    int          lat;
    logic [15:0] stall_mask;
    int          gap_after;
    int          gap_len;
    logic [31:0] wbase;
    logic        extra_ack;
    int          exp_beats;
    logic [10:0] exp_last;
    int          exp_max;
    int          exp_stb_low;
    int          exp_done_k;
    logic        exp_err;
  } vec_t;

  typedef struct {
    int          due;
    logic [31:0] data;
  } pend_t;

  vec_t  vecs[7];
  vec_t  rec_err;
  pend_t pend[$];
  int    checks = 0;
  int    failures = 0;

  function automatic logic [31:0] rdmem(input logic [10:0] a);
    return {16'hC0DE, 5'd0, a};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus_idle();
    cmd_valid = 1'b0; cmd_we = 1'b0; cmd_addr = 11'd0; cmd_len = 8'd0; cmd_sel = 4'd0;
    wdata_valid = 1'b0; wdata = 32'd0;
    ack = 1'b0; stall = 1'b0; data_i = 32'hBAD0BAD0;
  endtask

  task automatic applyStimulus_cmd(input logic w, input logic [10:0] a, input logic [7:0] l,
                                   input logic [3:0] s);
    check("cmd_ready_idle", 32'(cmd_ready), 32'd1);
    cmd_valid = 1'b1; cmd_we = w; cmd_addr = a; cmd_len = l; cmd_sel = s;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
  endtask

  // Runs one burst with a fixed-latency slave; k counts cycles after the command edge.
  task automatic checkOutput_burst(input vec_t v);
    int n, k, beats, acks, wbeat, gap, rd_cnt, max_out, done_cnt, done_k, last_ack_k;
    int cyc_bad, rv_bad, stb_low;
    logic        hold_chk, ack_prev, stall_now;
    logic [10:0] prev_addr, exp_addr, last_acc;
    logic [31:0] ack_prev_data;
    pend_t       p;
    n = int'(v.len) + 1;
    beats = 0; acks = 0; wbeat = 0; gap = 0; rd_cnt = 0; max_out = 0; done_cnt = 0;
    done_k = -10; last_ack_k = -10; cyc_bad = 0; rv_bad = 0; stb_low = 0;
    hold_chk = 1'b0; ack_prev = 1'b0; prev_addr = 11'd0; last_acc = 11'h7FF;
    ack_prev_data = 32'd0;
    pend.delete();
    exp_addr = v.addr & 11'h7FC;
    applyStimulus_cmd(v.we, v.addr, v.len, v.sel);
    k = 1;
    while (k < 200 && !(done_cnt > 0 && k > done_k + 2)) begin
      if (beats - acks > max_out) max_out = beats - acks;
      if (ack_prev && !v.we) begin
        if (!rdata_valid) rv_bad++;
        else begin
          rd_cnt++;
          check("rdata", rdata, ack_prev_data);
        end
      end else if (rdata_valid) rv_bad++;
      if (hold_chk) check("stall_hold", {20'd0, stb, addr}, {20'd0, 1'b1, prev_addr});
      if (done) begin
        done_cnt++;
        done_k = k;
        check("cyc_at_done", 32'(cyc), 32'd0);
      end else if ((done_cnt == 0) != cyc) cyc_bad++;
      if (cyc && !stb && beats > 0 && beats < n) stb_low++;

      ack_prev = 1'b0;
      if (pend.size() > 0 && pend[0].due == k) begin
        ack = 1'b1; data_i = pend[0].data;
        ack_prev = 1'b1; ack_prev_data = pend[0].data;
        void'(pend.pop_front());
        acks++;
        last_ack_k = k;
      end else if (v.extra_ack && acks == n && k == last_ack_k + 1) begin
        ack = 1'b1; data_i = 32'hBAD0BAD0;
      end else begin
        ack = 1'b0; data_i = 32'hBAD0BAD0;
      end
      stall_now = (k < 16) ? v.stall_mask[k] : 1'b0;
      stall = stall_now;
      if (v.we) begin
        if (gap > 0) begin
          wdata_valid = 1'b0;
          gap--;
        end else begin
          wdata_valid = (wbeat < n);
          wdata = v.wbase + 32'(wbeat) * 32'h01010101;
        end
      end
      #1;
      if (stb && !stall_now) begin
        check("addr", {21'd0, addr}, {21'd0, exp_addr});
        check("we_sel", {27'd0, we_o, sel}, {27'd0, v.we, v.sel});
        if (v.we) check("wdata_o", data_o, v.wbase + 32'(beats) * 32'h01010101);
        p.due = k + v.lat;
        p.data = rdmem(exp_addr);
        pend.push_back(p);
        last_acc = addr;
        exp_addr = exp_addr + 11'd4;
        beats++;
      end
      hold_chk = stb && stall_now;
      prev_addr = addr;
      if (wdata_valid && wdata_ready) begin
        wbeat++;
        if (wbeat == v.gap_after && v.gap_len > 0) gap = v.gap_len;
      end
      @(posedge clk); #1;
      k++;
    end
    applyStimulus_idle();
    check("beats", 32'(beats), 32'(v.exp_beats));
    check("acks", 32'(acks), 32'(n));
    check("last_addr", {21'd0, last_acc}, {21'd0, v.exp_last});
    check("max_outstanding", 32'(max_out), 32'(v.exp_max));
    check("stb_low_cycles", 32'(stb_low), 32'(v.exp_stb_low));
    check("done_count", 32'(done_cnt), 32'd1);
    check("done_cycle", 32'(done_k), 32'(v.exp_done_k));
    check("rd_count", 32'(rd_cnt), v.we ? 32'd0 : 32'(n));
    check("rdata_valid_stray", 32'(rv_bad), 32'd0);
    check("cyc_shape", 32'(cyc_bad), 32'd0);
    check("err_after_burst", 32'(err), 32'(v.exp_err));
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int bad;
    vecs[0] = '{1'b1, 11'h010, 8'd0, 4'hF, 1, 16'h0000, 0, 0, 32'hDEADBEEF, 1'b0,
                1, 11'h010, 1, 0, 4, 1'b0};
    vecs[1] = '{1'b0, 11'h400, 8'd3, 4'hF, 1, 16'h000C, 0, 0, 32'h0, 1'b0,
                4, 11'h40C, 1, 0, 8, 1'b0};
    vecs[2] = '{1'b0, 11'h7FC, 8'd1, 4'hF, 1, 16'h0000, 0, 0, 32'h0, 1'b0,
                2, 11'h000, 1, 0, 4, 1'b0};
    vecs[3] = '{1'b0, 11'h100, 8'd5, 4'hF, 3, 16'h0000, 0, 0, 32'h0, 1'b0,
                6, 11'h114, 2, 4, 14, 1'b0};
    vecs[4] = '{1'b1, 11'h020, 8'd3, 4'h3, 1, 16'h0000, 2, 4, 32'h11223344, 1'b0,
                4, 11'h02C, 1, 4, 11, 1'b0};
    vecs[5] = '{1'b1, 11'h7FB, 8'd2, 4'hF, 1, 16'h0006, 0, 0, 32'hA0B0C0D0, 1'b0,
                3, 11'h000, 1, 0, 7, 1'b0};
    vecs[6] = '{1'b0, 11'h3FC, 8'd0, 4'h8, 4, 16'h0000, 0, 0, 32'h0, 1'b0,
                1, 11'h3FC, 1, 0, 6, 1'b0};
    rec_err = '{1'b0, 11'h0F0, 8'd0, 4'hF, 1, 16'h0000, 0, 0, 32'h0, 1'b1,
                1, 11'h0F0, 1, 0, 3, 1'b1};

    applyStimulus_idle();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    check("rst_bus", {27'd0, cyc, stb, we_o, sel[1:0]}, 32'd0);
    check("rst_sel_addr", {17'd0, sel, addr}, 32'd0);
    check("rst_wdata_o", data_o, 32'd0);
    check("rst_rdata", rdata, 32'd0);
    check("rst_flags", {28'd0, rdata_valid, done, err, wdata_ready}, 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 7; i++) begin
      $display("[TB] burst vector %0d", i);
      checkOutput_burst(vecs[i]);
      @(posedge clk); #1;
    end

    $display("[TB] reset mid-burst");
    applyStimulus_cmd(1'b0, 11'h200, 8'd3, 4'hF);
    check("t6_k1", {20'd0, stb, addr}, {20'd0, 1'b1, 11'h200});
    @(posedge clk); #1;
    check("t6_k2", {20'd0, stb, addr}, {20'd0, 1'b1, 11'h204});
    ack = 1'b1; data_i = rdmem(11'h200);
    @(posedge clk); #1;
    check("t6_k3_rdata", {31'd0, rdata_valid}, 32'd1);
    check("t6_k3_rdata_val", rdata, rdmem(11'h200));
    check("t6_k3", {20'd0, stb, addr}, {20'd0, 1'b1, 11'h208});
    ack = 1'b1; data_i = rdmem(11'h204);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    applyStimulus_idle();
    check("t6_after_rst", {27'd0, cyc, stb, cmd_ready, done, rdata_valid}, 32'b00100);
    bad = 0;
    repeat (4) begin
      @(posedge clk); #1;
      if (done || cyc) bad++;
    end
    check("t6_quiet", 32'(bad), 32'd0);
    check("t6_err_clear", 32'(err), 32'd0);
    checkOutput_burst(vecs[1]);
    @(posedge clk); #1;

    $display("[TB] spurious acks");
    ack = 1'b1;
    @(posedge clk); #1;
    ack = 1'b0;
    check("t7_err_set", 32'(err), 32'd1);
    check("t7_idle", {29'd0, rdata_valid, cmd_ready, cyc}, 32'b010);
    @(posedge clk); #1;
    check("t7_err_sticky", 32'(err), 32'd1);
    checkOutput_burst(rec_err);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
